// File: rtl/cgra_pipe_pkg.sv
// Shared constants and types for the CGRA register-pipe companion blocks.
// ptr_w() sizes pointers and counters that must hold the value DEPTH itself.
package cgra_pipe_pkg;

    localparam int DEFAULT_DATA_W   = 8;
    localparam int DEFAULT_PIPE_LAT = 6;
    localparam int DEFAULT_DEPTH    = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [ptr_w(DEFAULT_DEPTH)-1:0] cnt_t;

endpackage

// File: rtl/pipe_fifo_credit_ctr.sv
// Credit pool for the register pipe: one credit per FIFO slot, consumed on launch
// and returned on pop. s_ready is a flop, so it has no combinational path from s_fire.
module pipe_fifo_credit_ctr
    import cgra_pipe_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic s_fire,
    input  logic pop,
    output logic s_ready,
    output logic err_proto
);

    localparam int CW = ptr_w(DEPTH);
    localparam logic [CW-1:0] FULL_CREDITS = CW'(DEPTH);
    localparam logic [CW-1:0] ONE          = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ZERO         = {CW{1'b0}};

    logic [CW-1:0] credits_r;
    logic [CW-1:0] credits_nxt_s;
    logic          s_ready_r;
    logic          err_proto_r;

    // Next credit value; a launch and a pop in one cycle cancel, both ends saturate
    always_comb begin
        credits_nxt_s = credits_r;
        if (s_fire && !pop) begin
            if (credits_r != ZERO) begin
                credits_nxt_s = credits_r - ONE;
            end else begin
                credits_nxt_s = credits_r;
            end
        end else if (pop && !s_fire) begin
            if (credits_r != FULL_CREDITS) begin
                credits_nxt_s = credits_r + ONE;
            end else begin
                credits_nxt_s = credits_r;
            end
        end else begin
            credits_nxt_s = credits_r;
        end
    end

    // Credit register, ready flag and sticky protocol error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits_r   <= FULL_CREDITS;
            s_ready_r   <= 1'b1;
            err_proto_r <= 1'b0;
        end else begin
            credits_r   <= credits_nxt_s;
            s_ready_r   <= (credits_nxt_s != ZERO);
            err_proto_r <= err_proto_r | (s_fire & ~s_ready_r);
        end
    end

    assign s_ready   = s_ready_r;
    assign err_proto = err_proto_r;

endmodule

// File: rtl/pipe_credit_fifo.sv
// Capture FIFO behind the no-backpressure register pipe, with credit return and a
// FWFT valid/ready output. Optional high-water mark port: PIPE_FIFO_WATERMARK_EN.
module pipe_credit_fifo
    import cgra_pipe_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int PIPE_LAT = DEFAULT_PIPE_LAT,
    parameter int DEPTH    = DEFAULT_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    s_ready,
    input  logic                    s_fire,
    input  logic                    p_valid,
    input  logic [DATA_W-1:0]       p_data,
    output logic                    m_tvalid,
    output logic [DATA_W-1:0]       m_tdata,
    input  logic                    m_tready,
    output logic [ptr_w(DEPTH)-1:0] count,
    output logic                    err_overflow,
    output logic                    err_proto
`ifdef PIPE_FIFO_WATERMARK_EN
    ,
    output logic [ptr_w(DEPTH)-1:0] hwm
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    if (PIPE_LAT < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("pipe_credit_fifo: PIPE_LAT must be >= 1 and DEPTH a power of 2 >= 2");
    end

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic              err_overflow_r;
    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              push_s;

    // Pointers carry a wrap bit so full and empty are distinguishable
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign pop_s   = ~empty_s & m_tready;
    assign push_s  = p_valid & (~full_s | pop_s);

    pipe_fifo_credit_ctr #(
        .DEPTH (DEPTH)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .s_fire    (s_fire),
        .pop       (pop_s),
        .s_ready   (s_ready),
        .err_proto (err_proto)
    );

    // Storage is cleared on reset so the head word reads zero until the first push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= p_data;
        end
    end

    // Pointer advance and sticky overflow on a dropped word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r       <= {PW{1'b0}};
            rd_ptr_r       <= {PW{1'b0}};
            err_overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            err_overflow_r <= err_overflow_r | (p_valid & ~push_s);
        end
    end

    assign m_tvalid     = ~empty_s;
    assign m_tdata      = mem_r[rd_ptr_r[AW-1:0]];
    assign count        = wr_ptr_r - rd_ptr_r;
    assign err_overflow = err_overflow_r;

`ifdef PIPE_FIFO_WATERMARK_EN
    logic [PW-1:0] hwm_r;

    // Running maximum of occupancy, trailing count by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hwm_r <= {PW{1'b0}};
        end else if (count > hwm_r) begin
            hwm_r <= count;
        end else begin
            hwm_r <= hwm_r;
        end
    end

    assign hwm = hwm_r;
`endif

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// Bench for pipe_credit_fifo: 6-stage pipe model, scoreboard queue and occupancy/credit model.
module tb_pipe_credit_fifo;
    import cgra_pipe_pkg::*;

    localparam int DATA_W   = 8;
    localparam int PIPE_LAT = 6;
    localparam int DEPTH    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              s_ready;
    logic              s_fire = 1'b0;
    logic              p_valid;
    logic [DATA_W-1:0] p_data;
    logic              m_tvalid;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tready = 1'b1;
    cnt_t              count;
    logic              err_overflow;
    logic              err_proto;
`ifdef PIPE_FIFO_WATERMARK_EN
    cnt_t              hwm;
`endif

    logic [DATA_W-1:0] fire_data = 8'h00;
    logic              frc_valid = 1'b0;
    logic [DATA_W-1:0] frc_data  = 8'h00;
    logic [PIPE_LAT-1:0] pv_r;
    logic [DATA_W-1:0]   pd_r [PIPE_LAT];

    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    int   credits_m = DEPTH;
    int   inflight = 0;
    bit   inv_en = 1'b1;
    bit   mon_en = 1'b0;
    bit   pop_m;
    bit   push_m;
    logic [DATA_W-1:0] exp_d;
    logic [DATA_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    pipe_credit_fifo #(
        .DATA_W   (DATA_W),
        .PIPE_LAT (PIPE_LAT),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_ready      (s_ready),
        .s_fire       (s_fire),
        .p_valid      (p_valid),
        .p_data       (p_data),
        .m_tvalid     (m_tvalid),
        .m_tdata      (m_tdata),
        .m_tready     (m_tready),
        .count        (count),
        .err_overflow (err_overflow),
        .err_proto    (err_proto)
`ifdef PIPE_FIFO_WATERMARK_EN
        ,
        .hwm          (hwm)
`endif
    );

    // Upstream register pipe model, reset on the same rst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv_r <= '0;
            for (int i = 0; i < PIPE_LAT; i++) pd_r[i] <= 8'h00;
        end else begin
            pv_r    <= {pv_r[PIPE_LAT-2:0], s_fire};
            pd_r[0] <= fire_data;
            for (int i = 1; i < PIPE_LAT; i++) pd_r[i] <= pd_r[i-1];
        end
    end

    assign p_valid = frc_valid | pv_r[PIPE_LAT-1];
    assign p_data  = frc_valid ? frc_data : pd_r[PIPE_LAT-1];

    // Scoreboard and occupancy/credit model, evaluated mid-cycle
    always @(negedge clk) begin
        if (rst && mon_en) begin
            pop_m = (model_cnt != 0) && m_tready;
            checks++;
            if (count !== cnt_t'(model_cnt)) begin
                errors++; $display("FAIL count: got %0d want %0d at %0t", count, model_cnt, $time);
            end
            checks++;
            if (m_tvalid !== (model_cnt != 0)) begin
                errors++; $display("FAIL m_tvalid: got %b want %b at %0t", m_tvalid, model_cnt != 0, $time);
            end
            checks++;
            if (s_ready !== (credits_m != 0)) begin
                errors++; $display("FAIL s_ready: got %b want %b at %0t", s_ready, credits_m != 0, $time);
            end
            checks++;
            if (dut.u_credit.credits_r !== cnt_t'(credits_m)) begin
                errors++; $display("FAIL credits: got %0d want %0d at %0t", dut.u_credit.credits_r, credits_m, $time);
            end
            if (inv_en) begin
                checks++;
                if (int'(dut.u_credit.credits_r) + int'(count) + inflight != DEPTH) begin
                    errors++; $display("FAIL invariant: got %0d want %0d at %0t",
                                       int'(dut.u_credit.credits_r) + int'(count) + inflight, DEPTH, $time);
                end
            end
            if (pop_m) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL scoreboard: got pop of %h want no word at %0t", m_tdata, $time);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (m_tdata !== exp_d) begin
                        errors++; $display("FAIL m_tdata: got %h want %h at %0t", m_tdata, exp_d, $time);
                    end
                end
            end
            push_m    = p_valid && ((model_cnt < DEPTH) || pop_m);
            model_cnt = model_cnt + int'(push_m) - int'(pop_m);
            if (s_fire && !pop_m && credits_m != 0) credits_m--;
            else if (pop_m && !s_fire && credits_m != DEPTH) credits_m++;
            inflight = inflight + int'(s_fire) - int'(pv_r[PIPE_LAT-1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [DATA_W-1:0] d, input bit keep);
        s_fire    = 1'b1;
        fire_data = d;
        if (keep) exp_q.push_back(d);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({s_ready, m_tvalid, count, m_tdata, err_overflow, err_proto} !== {1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_hold: got %b %b %0d %h %b %b", s_ready, m_tvalid, count, m_tdata, err_overflow, err_proto);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        mon_en = 1'b1;
        repeat (3) step();
        checks++;
        if ({s_ready, m_tvalid, count, dut.u_credit.credits_r} !== {1'b1, 1'b0, 4'd0, 4'd8}) begin
            errors++; $display("FAIL reset_release: got %b %b %0d %0d want 1 0 0 8", s_ready, m_tvalid, count, dut.u_credit.credits_r);
        end
`ifdef PIPE_FIFO_WATERMARK_EN
        checks++;
        if (hwm !== 4'd0) begin
            errors++; $display("FAIL hwm_reset: got %0d want 0", hwm);
        end
`endif
    endtask

    task automatic test_back_to_back();
        m_tready = 1'b1;
        launch(8'h01, 1'b1); step();
        launch(8'h02, 1'b1); step();
        launch(8'h03, 1'b1); step();
        s_fire = 1'b0;
        repeat (3) step();
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++; $display("FAIL latency_early: got m_tvalid %b want 0", m_tvalid);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if ({m_tvalid, m_tdata} !== {1'b1, 8'(i)}) begin
                errors++; $display("FAIL latency_word%0d: got %b %h want 1 %h", i, m_tvalid, m_tdata, 8'(i));
            end
        end
        step();
        checks++;
        if ({m_tvalid, dut.u_credit.credits_r} !== {1'b0, 4'd8}) begin
            errors++; $display("FAIL b2b_drain: got %b %0d want 0 8", m_tvalid, dut.u_credit.credits_r);
        end
    endtask

    task automatic test_fill();
        int fires = 0;
        m_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (s_ready !== 1'b1) break;
            launch(8'(32'h10 + i), 1'b1);
            fires++;
            step();
        end
        s_fire = 1'b0;
        checks++;
        if (fires != DEPTH) begin
            errors++; $display("FAIL fill_fires: got %0d want %0d", fires, DEPTH);
        end
        repeat (8) step();
        checks++;
        if ({count, s_ready, err_overflow, m_tdata} !== {4'd8, 1'b0, 1'b0, 8'h10}) begin
            errors++; $display("FAIL fill_state: got %0d %b %b %h want 8 0 0 10", count, s_ready, err_overflow, m_tdata);
        end
`ifdef PIPE_FIFO_WATERMARK_EN
        checks++;
        if (hwm !== 4'd8) begin
            errors++; $display("FAIL hwm_full: got %0d want 8", hwm);
        end
`endif
    endtask

    task automatic test_full_push_pop();
        inv_en    = 1'b0;
        m_tready  = 1'b1;
        frc_valid = 1'b1;
        frc_data  = 8'hA5;
        exp_q.push_back(8'hA5);
        step();
        m_tready  = 1'b0;
        frc_valid = 1'b0;
        checks++;
        if ({count, m_tdata, err_overflow, s_ready} !== {4'd8, 8'h11, 1'b0, 1'b1}) begin
            errors++; $display("FAIL full_push_pop: got %0d %h %b %b want 8 11 0 1", count, m_tdata, err_overflow, s_ready);
        end
    endtask

    task automatic test_overflow_proto();
        frc_valid = 1'b1;
        frc_data  = 8'h5A;
        step();
        frc_valid = 1'b0;
        checks++;
        if ({count, m_tdata, err_overflow} !== {4'd8, 8'h11, 1'b1}) begin
            errors++; $display("FAIL overflow: got %0d %h %b want 8 11 1", count, m_tdata, err_overflow);
        end
        launch(8'h77, 1'b0); step();
        s_fire = 1'b0;
        checks++;
        if ({s_ready, err_proto} !== {1'b0, 1'b0}) begin
            errors++; $display("FAIL legal_fire: got %b %b want 0 0", s_ready, err_proto);
        end
        launch(8'h66, 1'b0); step();
        s_fire = 1'b0;
        checks++;
        if ({s_ready, err_proto} !== {1'b0, 1'b1}) begin
            errors++; $display("FAIL proto: got %b %b want 0 1", s_ready, err_proto);
        end
        repeat (8) step();
        checks++;
        if ({count, m_tdata, err_overflow, err_proto} !== {4'd8, 8'h11, 1'b1, 1'b1}) begin
            errors++; $display("FAIL sticky: got %0d %h %b %b want 8 11 1 1", count, m_tdata, err_overflow, err_proto);
        end
    endtask

    task automatic test_async_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (m_tvalid === 1'b0) break;
            step();
        end
        checks++;
        if ({m_tvalid, dut.u_credit.credits_r} !== {1'b0, 4'd8} || exp_q.size() != 0) begin
            errors++; $display("FAIL drain: got %b %0d left %0d want 0 8 0", m_tvalid, dut.u_credit.credits_r, exp_q.size());
        end
        m_tready = 1'b0;
        inv_en   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            launch(8'(32'h30 + i), 1'b1);
            step();
        end
        s_fire = 1'b0;
        repeat (3) step();
        checks++;
        if (count !== 4'd4) begin
            errors++; $display("FAIL pre_reset: got %0d want 4", count);
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({m_tvalid, count, s_ready, err_overflow, err_proto, m_tdata, p_valid} !==
            {1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            errors++; $display("FAIL async_reset: got %b %0d %b %b %b %h %b", m_tvalid, count, s_ready,
                               err_overflow, err_proto, m_tdata, p_valid);
        end
        exp_q.delete();
        model_cnt = 0;
        credits_m = DEPTH;
        inflight  = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (10) step();
        checks++;
        if ({m_tvalid, count, dut.u_credit.credits_r} !== {1'b0, 4'd0, 4'd8}) begin
            errors++; $display("FAIL post_reset: got %b %0d %0d want 0 0 8", m_tvalid, count, dut.u_credit.credits_r);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fill();
        test_full_push_pop();
        test_overflow_proto();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
